spi_accel_slave_model: RTL and testbench

- Parametrised, synthesizable SPI slave that emulates a 3-axis accelerometer register map.
- Successor to the fixed single-mode SPI slave: adds selectable CPOL/CPHA, configurable register depth, ADXL-style multi-byte auto-increment, coherent sample snapshot and a data-ready interrupt.
- Runs entirely on the system clock by oversampling SCL, CS and MOSI.
- Sits opposite the SPI master in system benches and on the FPGA for loopback bring-up.

---
 rtl/spi_accel_slave_model.sv | 256 +++++++++++++++++++++++++
 tb/tb_spi_accel_slave_model.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_accel_slave_model.sv
// spi_accel_slave_model: SPI slave emulating a 3-axis accelerometer
// register map, oversampled on the system clock.
module spi_accel_slave_model #(
   parameter int                NUM_REGS    = 64,
   parameter int                ADDR_W      = 6,
   parameter int                CPOL        = 1,
   parameter int                CPHA        = 1,
   parameter int                SYNC_STAGES = 2,
   parameter logic [7:0]        DEVID       = 8'hE5,
   parameter logic [ADDR_W-1:0] DATA_BASE   = ADDR_W'('h32)
) (
   input  logic        sys_clock,
   input  logic        reset,
   input  logic        SCL,
   input  logic        CS,
   input  logic        MOSI,
   output logic        MISO,
   output logic        miso_oe,
   input  logic        sample_valid,
   input  logic [15:0] sample_x,
   input  logic [15:0] sample_y,
   input  logic [15:0] sample_z,
   output logic        INT1,
   output logic        busy,
   output logic [7:0]  frame_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CMD,
      S_DATA
   } state_e;

   localparam logic SCL_IDLE    = (CPOL != 0);
   localparam logic SAMPLE_RISE = (CPOL == CPHA);

   localparam logic [ADDR_W-1:0] A_XL = DATA_BASE;
   localparam logic [ADDR_W-1:0] A_XH = DATA_BASE + ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A_YL = DATA_BASE + ADDR_W'(2);
   localparam logic [ADDR_W-1:0] A_YH = DATA_BASE + ADDR_W'(3);
   localparam logic [ADDR_W-1:0] A_ZL = DATA_BASE + ADDR_W'(4);
   localparam logic [ADDR_W-1:0] A_ZH = DATA_BASE + ADDR_W'(5);

   logic [SYNC_STAGES-1:0] scl_sync_q;
   logic [SYNC_STAGES-1:0] cs_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic                   scl_prev_q;
   logic                   cs_prev_q;

   state_e state_q, state_d;

   logic [2:0]        cnt_q;
   logic [6:0]        sh_in_q;
   logic [7:0]        sh_out_q;
   logic              rw_q;
   logic              mb_q;
   logic [ADDR_W-1:0] addr_q;
   logic              miso_q;
   logic              oe_q;
   logic [7:0]        frame_q;
   logic              commit_q;
   logic              int_q;

   logic              pend_valid_q;
   logic [15:0]       pend_x_q;
   logic [15:0]       pend_y_q;
   logic [15:0]       pend_z_q;

   logic [7:0]        regs_q [NUM_REGS];

   logic              scl_s, cs_s, mosi_s;
   logic              scl_rise, scl_fall;
   logic              cs_rise, cs_fall;
   logic              sample_edge, shift_edge;
   logic              live, smp, shf;
   logic              cmd_done, data_done, end_txn;
   logic [7:0]        cap_byte;
   logic [ADDR_W-1:0] cmd_addr;
   logic [ADDR_W-1:0] addr_nxt;
   logic              load_now, ld_en;
   logic [15:0]       ld_x, ld_y, ld_z;
   logic              int_set, int_clr;

   function automatic logic is_data(input logic [ADDR_W-1:0] a);
      return (a >= DATA_BASE) &&
             ({1'b0, a} <= ({1'b0, DATA_BASE} + (ADDR_W+1)'(5)));
   endfunction

   assign scl_s  = scl_sync_q[SYNC_STAGES-1];
   assign cs_s   = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   assign scl_rise = scl_s & ~scl_prev_q;
   assign scl_fall = ~scl_s & scl_prev_q;
   assign cs_rise  = cs_s & ~cs_prev_q;
   assign cs_fall  = ~cs_s & cs_prev_q;

   assign sample_edge = SAMPLE_RISE ? scl_rise : scl_fall;
   assign shift_edge  = SAMPLE_RISE ? scl_fall : scl_rise;

   assign live      = (state_q != S_IDLE) && !cs_s;
   assign smp       = sample_edge & live;
   assign shf       = shift_edge & live;
   assign cmd_done  = smp && (cnt_q == 3'd7) && (state_q == S_CMD);
   assign data_done = smp && (cnt_q == 3'd7) && (state_q == S_DATA);
   assign end_txn   = cs_rise && (state_q != S_IDLE);

   assign cap_byte = {sh_in_q, mosi_s};
   assign cmd_addr = cap_byte[ADDR_W-1:0];
   assign addr_nxt = mb_q ? addr_q + ADDR_W'(1) : addr_q;

   assign load_now = sample_valid && (state_q == S_IDLE);
   assign ld_en    = load_now || (commit_q && pend_valid_q);
   assign ld_x     = load_now ? sample_x : pend_x_q;
   assign ld_y     = load_now ? sample_y : pend_y_q;
   assign ld_z     = load_now ? sample_z : pend_z_q;

   assign int_set = ld_en;
   assign int_clr = cmd_done && cap_byte[7] && is_data(cmd_addr);

   assign MISO        = miso_q;
   assign miso_oe     = oe_q;
   assign INT1        = int_q;
   assign busy        = (state_q != S_IDLE);
   assign frame_count = frame_q;

   // Pin synchronisers; CS chain resets low so a frame in flight
   // across reset produces no falling edge until CS is cycled.
   always_ff @(posedge sys_clock or posedge reset) begin
      if (reset) begin
         scl_sync_q  <= {SYNC_STAGES{SCL_IDLE}};
         cs_sync_q   <= '0;
         mosi_sync_q <= '0;
         scl_prev_q  <= SCL_IDLE;
         cs_prev_q   <= 1'b0;
      end else begin
         scl_sync_q  <= {scl_sync_q[SYNC_STAGES-2:0], SCL};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
         scl_prev_q  <= scl_s;
         cs_prev_q   <= cs_s;
      end
   end

   // Transaction state register.
   always_ff @(posedge sys_clock or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state: CS framing plus command byte completion.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (cs_fall) state_d = S_CMD;
         S_CMD: begin
            if (end_txn)       state_d = S_IDLE;
            else if (cmd_done) state_d = S_DATA;
         end
         S_DATA: if (end_txn) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Bit counter, shift registers, address pointer and MISO driver.
   always_ff @(posedge sys_clock or posedge reset) begin
      if (reset) begin
         cnt_q    <= '0;
         sh_in_q  <= '0;
         sh_out_q <= '0;
         rw_q     <= 1'b0;
         mb_q     <= 1'b0;
         addr_q   <= '0;
         miso_q   <= 1'b0;
         oe_q     <= 1'b0;
         frame_q  <= '0;
         commit_q <= 1'b0;
      end else begin
         commit_q <= end_txn;
         if ((state_q == S_IDLE) && cs_fall) begin
            cnt_q  <= '0;
            miso_q <= 1'b0;
            oe_q   <= 1'b0;
         end
         if (end_txn) begin
            cnt_q  <= '0;
            miso_q <= 1'b0;
            oe_q   <= 1'b0;
            if (state_q == S_DATA) frame_q <= frame_q + 8'd1;
         end
         if (smp) begin
            cnt_q   <= cnt_q + 3'd1;
            sh_in_q <= cap_byte[6:0];
         end
         if (cmd_done) begin
            rw_q   <= cap_byte[7];
            mb_q   <= cap_byte[6];
            addr_q <= cmd_addr;
            if (cap_byte[7]) sh_out_q <= regs_q[cmd_addr];
         end
         if (data_done) begin
            addr_q <= addr_nxt;
            if (rw_q) sh_out_q <= regs_q[addr_nxt];
         end
         if (shf && (state_q == S_DATA) && rw_q) begin
            miso_q   <= sh_out_q[7];
            sh_out_q <= {sh_out_q[6:0], 1'b0};
            oe_q     <= 1'b1;
         end
      end
   end

   // Samples arriving mid-frame wait here; the last one wins.
   always_ff @(posedge sys_clock or posedge reset) begin
      if (reset) begin
         pend_valid_q <= 1'b0;
         pend_x_q     <= '0;
         pend_y_q     <= '0;
         pend_z_q     <= '0;
      end else if (sample_valid && (state_q != S_IDLE)) begin
         pend_valid_q <= 1'b1;
         pend_x_q     <= sample_x;
         pend_y_q     <= sample_y;
         pend_z_q     <= sample_z;
      end else if (commit_q) begin
         pend_valid_q <= 1'b0;
      end
   end

   // Data-ready level: a new sample set overrides a concurrent clear.
   always_ff @(posedge sys_clock or posedge reset) begin
      if (reset)        int_q <= 1'b0;
      else if (int_set) int_q <= 1'b1;
      else if (int_clr) int_q <= 1'b0;
   end

   // Register file; DEVID and the sample block are not host-writable.
   always_ff @(posedge sys_clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
         regs_q[0] <= DEVID;
      end else begin
         if (data_done && !rw_q && (addr_q != '0) && !is_data(addr_q))
            regs_q[addr_q] <= cap_byte;
         if (ld_en) begin
            regs_q[A_XL] <= ld_x[7:0];
            regs_q[A_XH] <= ld_x[15:8];
            regs_q[A_YL] <= ld_y[7:0];
            regs_q[A_YH] <= ld_y[15:8];
            regs_q[A_ZL] <= ld_z[7:0];
            regs_q[A_ZH] <= ld_z[15:8];
         end
      end
   end

endmodule

// File: tb/tb_spi_accel_slave_model.sv
// Bench for spi_accel_slave_model: two instances (mode 3 and mode 0)
// driven by a bit-level SPI master and checked against a register model.
module tb_spi_accel_slave_model;

   logic        clk = 1'b0;
   logic        rst;
   logic        scl11, cs11, scl00, cs00, mosi;
   logic        miso11, oe11, int11, busy11;
   logic        miso00, oe00, int00, busy00;
   logic [7:0]  fc11, fc00;
   logic        sv, sv00;
   logic [15:0] sx, sy, sz;

   int errors = 0;
   int checks = 0;

   logic [7:0]  m_regs [2][64];
   bit          m_int  [2];
   int          m_fc   [2];
   bit          m_pv;
   logic [15:0] m_px, m_py, m_pz;

   logic [7:0]  wbuf [8];
   logic [7:0]  rbuf [8];
   int          inj_byte = -1;
   logic [15:0] inj_x, inj_y, inj_z;
   bit          oe_bad;

   always #5 clk = ~clk;

   spi_accel_slave_model #(.CPOL(1), .CPHA(1)) u11 (
      .sys_clock(clk), .reset(rst), .SCL(scl11), .CS(cs11),
      .MOSI(mosi), .MISO(miso11), .miso_oe(oe11),
      .sample_valid(sv), .sample_x(sx), .sample_y(sy),
      .sample_z(sz), .INT1(int11), .busy(busy11),
      .frame_count(fc11)
   );

   spi_accel_slave_model #(.CPOL(0), .CPHA(0)) u00 (
      .sys_clock(clk), .reset(rst), .SCL(scl00), .CS(cs00),
      .MOSI(mosi), .MISO(miso00), .miso_oe(oe00),
      .sample_valid(sv00), .sample_x(sx), .sample_y(sy),
      .sample_z(sz), .INT1(int00), .busy(busy00),
      .frame_count(fc00)
   );

   function automatic bit in_data(input logic [5:0] a);
      return (a >= 6'h32) && (a <= 6'h37);
   endfunction

   function automatic logic miso_of(input int m);
      return (m == 0) ? miso11 : miso00;
   endfunction

   function automatic logic oe_of(input int m);
      return (m == 0) ? oe11 : oe00;
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 64; i++) m_regs[m][i] = 8'h00;
         m_regs[m][0] = 8'hE5;
         m_int[m] = 1'b0;
         m_fc[m]  = 0;
      end
      m_pv = 1'b0;
   endtask

   task automatic model_load(input logic [15:0] x, y, z);
      m_regs[0][6'h32] = x[7:0];
      m_regs[0][6'h33] = x[15:8];
      m_regs[0][6'h34] = y[7:0];
      m_regs[0][6'h35] = y[15:8];
      m_regs[0][6'h36] = z[7:0];
      m_regs[0][6'h37] = z[15:8];
      m_int[0] = 1'b1;
   endtask

   task automatic half();
      repeat (8) @(negedge clk);
   endtask

   task automatic set_scl(input int m, input logic v);
      if (m == 0) scl11 = v;
      else        scl00 = v;
   endtask

   task automatic set_cs(input int m, input logic v);
      if (m == 0) cs11 = v;
      else        cs00 = v;
   endtask

   task automatic xfer_bits(input int m, input logic [7:0] tx,
                            input int nbits, input bit is_data,
                            output logic [7:0] rx);
      logic cpol, cpha;
      cpol = (m == 0);
      cpha = (m == 0);
      rx = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         if (!cpha) begin
            mosi = tx[7-i];
            half();
            set_scl(m, ~cpol);
            rx = {rx[6:0], miso_of(m)};
            if (oe_of(m) !== is_data) oe_bad = 1'b1;
            half();
            set_scl(m, cpol);
         end else begin
            set_scl(m, ~cpol);
            mosi = tx[7-i];
            half();
            set_scl(m, cpol);
            rx = {rx[6:0], miso_of(m)};
            if (oe_of(m) !== is_data) oe_bad = 1'b1;
            half();
         end
      end
   endtask

   task automatic apply_sample(input logic [15:0] x, y, z);
      sx = x; sy = y; sz = z;
      sv = 1'b1;
      @(negedge clk);
      sv = 1'b0;
      model_load(x, y, z);
      repeat (3) @(negedge clk);
   endtask

   task automatic txn(input int m, input logic [7:0] cmd,
                      input int nbytes, input int tail_bits);
      logic [7:0] rx, exp_b;
      logic [5:0] a;
      bit         rw, mb;
      rw = cmd[7];
      mb = cmd[6];
      a  = cmd[5:0];
      oe_bad = 1'b0;
      set_cs(m, 1'b0);
      half();
      xfer_bits(m, cmd, 8, 1'b0, rx);
      if (rw && in_data(a)) m_int[m] = 1'b0;
      if (m == 0) begin
         checks++;
         if (int11 !== m_int[0])
            $display("FAIL int1_after_cmd %h: got %b want %b",
                     cmd, int11, m_int[0]);
         if (int11 !== m_int[0]) errors++;
      end
      for (int k = 0; k < nbytes; k++) begin
         if (m == 0 && k == inj_byte) begin
            sx = inj_x; sy = inj_y; sz = inj_z;
            sv = 1'b1;
            @(negedge clk);
            sv = 1'b0;
            m_pv = 1'b1;
            m_px = inj_x; m_py = inj_y; m_pz = inj_z;
         end
         if (rw) begin
            exp_b = m_regs[m][a];
            xfer_bits(m, 8'h00, 8, 1'b1, rx);
            rbuf[k] = rx;
            checks++;
            if (rx !== exp_b) begin
               errors++;
               $display("FAIL read m%0d addr %h byte%0d: got %h want %h",
                        m, a, k, rx, exp_b);
            end
         end else begin
            xfer_bits(m, wbuf[k], 8, 1'b0, rx);
            if (a != 6'h00 && !in_data(a)) m_regs[m][a] = wbuf[k];
         end
         if (mb) a = a + 6'd1;
      end
      if (tail_bits > 0) xfer_bits(m, wbuf[nbytes], tail_bits, rw, rx);
      checks++;
      if (oe_bad !== 1'b0) begin
         errors++;
         $display("FAIL miso_oe_window cmd %h: got bad=%b want 0",
                  cmd, oe_bad);
      end
      half();
      set_cs(m, 1'b1);
      repeat (12) @(negedge clk);
      m_fc[m] = (m_fc[m] + 1) % 256;
      if (m == 0 && m_pv) begin
         model_load(m_px, m_py, m_pz);
         m_pv = 1'b0;
      end
      checks++;
      if (((m == 0) ? fc11 : fc00) !== 8'(m_fc[m])) begin
         errors++;
         $display("FAIL frame_count m%0d: got %0d want %0d",
                  m, (m == 0) ? fc11 : fc00, m_fc[m]);
      end
      checks++;
      if ({miso_of(m), oe_of(m)} !== 2'b00) begin
         errors++;
         $display("FAIL idle_miso m%0d: got %b%b want 00",
                  m, miso_of(m), oe_of(m));
      end
      if (m == 0) begin
         checks++;
         if (int11 !== m_int[0]) begin
            errors++;
            $display("FAIL int1_after_frame: got %b want %b",
                     int11, m_int[0]);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({miso11, oe11, int11, busy11, fc11} !== 12'h000) begin
         errors++;
         $display("FAIL reset_u11: got %b%b%b%b %h want 0",
                  miso11, oe11, int11, busy11, fc11);
      end
      rst = 1'b0;
      repeat (6) @(negedge clk);
      checks++;
      if ({miso11, oe11, int11, busy11, fc11} !== 12'h000) begin
         errors++;
         $display("FAIL post_reset_u11: got %b%b%b%b %h want 0",
                  miso11, oe11, int11, busy11, fc11);
      end
      checks++;
      if ({miso00, oe00, int00, busy00, fc00} !== 12'h000) begin
         errors++;
         $display("FAIL post_reset_u00: got %b%b%b%b %h want 0",
                  miso00, oe00, int00, busy00, fc00);
      end
   endtask

   task automatic test_devid();
      txn(0, 8'h80, 1, 0);
      checks++;
      if (rbuf[0] !== 8'hE5) begin
         errors++;
         $display("FAIL devid: got %h want e5", rbuf[0]);
      end
   endtask

   task automatic test_write_read();
      logic [5:0] a;
      logic [7:0] d;
      wbuf[0] = 8'h08;
      txn(0, 8'h2D, 1, 0);
      txn(0, 8'hAD, 1, 0);
      checks++;
      if (rbuf[0] !== 8'h08) begin
         errors++;
         $display("FAIL reg2d: got %h want 08", rbuf[0]);
      end
      wbuf[0] = 8'hFF;
      txn(0, 8'h00, 1, 0);
      txn(0, 8'h80, 1, 0);
      checks++;
      if (rbuf[0] !== 8'hE5) begin
         errors++;
         $display("FAIL devid_protect: got %h want e5", rbuf[0]);
      end
      repeat (3) begin
         do a = 6'($urandom_range(1, 63)); while (in_data(a));
         d = 8'($urandom);
         wbuf[0] = d;
         txn(0, {2'b00, a}, 1, 0);
         txn(0, {2'b10, a}, 1, 0);
      end
   endtask

   task automatic test_samples();
      apply_sample(16'h1234, 16'hFFFE, 16'h0100);
      checks++;
      if (int11 !== 1'b1) begin
         errors++;
         $display("FAIL int1_set: got %b want 1", int11);
      end
      inj_byte = 2;
      inj_x = 16'hAAAA;
      inj_y = 16'($urandom);
      inj_z = 16'($urandom);
      txn(0, 8'hF2, 6, 0);
      inj_byte = -1;
      checks++;
      if ({rbuf[0], rbuf[1], rbuf[2], rbuf[3], rbuf[4], rbuf[5]}
          !== 48'h3412FEFF0001) begin
         errors++;
         $display("FAIL coherent_burst: got %h%h%h%h%h%h want 3412feff0001",
                  rbuf[0], rbuf[1], rbuf[2], rbuf[3], rbuf[4], rbuf[5]);
      end
      txn(0, 8'hB2, 1, 0);
      checks++;
      if (rbuf[0] !== 8'hAA) begin
         errors++;
         $display("FAIL pending_commit: got %h want aa", rbuf[0]);
      end
   endtask

   task automatic test_wrap();
      txn(0, 8'hFF, 2, 0);
      checks++;
      if (rbuf[1] !== 8'hE5) begin
         errors++;
         $display("FAIL addr_wrap: got %h want e5", rbuf[1]);
      end
   endtask

   task automatic test_partial();
      wbuf[0] = 8'h5A;
      txn(0, 8'h2D, 0, 5);
      txn(0, 8'hAD, 1, 0);
      checks++;
      if (rbuf[0] !== 8'h08) begin
         errors++;
         $display("FAIL partial_discard: got %h want 08", rbuf[0]);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] cmd;
      int         n;
      repeat (10) begin
         cmd = 8'($urandom);
         n = $urandom_range(1, 4);
         for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
         inj_byte = ($urandom % 2 == 0) ? $urandom_range(0, n - 1) : -1;
         inj_x = 16'($urandom);
         inj_y = 16'($urandom);
         inj_z = 16'($urandom);
         txn(0, cmd, n, 0);
         inj_byte = -1;
         if ($urandom % 3 == 0)
            apply_sample(16'($urandom), 16'($urandom), 16'($urandom));
      end
   endtask

   task automatic test_mode00_reset();
      logic [7:0] rx;
      txn(1, 8'h80, 1, 0);
      cs00 = 1'b0;
      half();
      xfer_bits(1, 8'h80, 8, 1'b0, rx);
      xfer_bits(1, 8'h00, 3, 1'b1, rx);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({miso00, oe00, int00, busy00, fc00} !== 12'h000) begin
         errors++;
         $display("FAIL midreset_u00: got %b%b%b%b %h want 0",
                  miso00, oe00, int00, busy00, fc00);
      end
      checks++;
      if ({int11, fc11} !== 9'h000) begin
         errors++;
         $display("FAIL midreset_u11: got %b %h want 0", int11, fc11);
      end
      rst = 1'b0;
      oe_bad = 1'b0;
      xfer_bits(1, 8'hFF, 5, 1'b0, rx);
      checks++;
      if ({busy00, oe_bad, miso00} !== 3'b000) begin
         errors++;
         $display("FAIL ignore_after_reset: got %b%b%b want 000",
                  busy00, oe_bad, miso00);
      end
      half();
      cs00 = 1'b1;
      repeat (12) @(negedge clk);
      model_reset();
      txn(1, 8'h80, 1, 0);
      txn(0, 8'h80, 1, 0);
   endtask

   initial begin
      rst   = 1'b1;
      scl11 = 1'b1;
      cs11  = 1'b1;
      scl00 = 1'b0;
      cs00  = 1'b1;
      mosi  = 1'b0;
      sv    = 1'b0;
      sv00  = 1'b0;
      sx    = '0;
      sy    = '0;
      sz    = '0;
      model_reset();
      test_reset();
      test_devid();
      test_write_read();
      test_samples();
      test_wrap();
      test_partial();
      test_back_to_back();
      test_mode00_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
